// File: rtl/sa_skew_feeder_if.sv
// rtl/sa_skew_feeder_if.sv - operand write, launch and PE-edge output bundle for sa_skew_feeder
interface sa_skew_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int K_MAX      = 16
);
  localparam int LW = $clog2(N);
  localparam int AW = $clog2(K_MAX);

  logic                      wr_en;
  logic                      wr_sel;
  logic [LW-1:0]             wr_lane;
  logic [AW-1:0]             wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [AW:0]               k_len;
  logic                      start;
  logic [N*DATA_WIDTH-1:0]   fd_out;
  logic [N*2*DATA_WIDTH-1:0] rd_out;
  logic                      result_ld;
  logic                      busy;
  logic                      done;

  modport master (
    output wr_en, wr_sel, wr_lane, wr_addr, wr_data, k_len, start,
    input  fd_out, rd_out, result_ld, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_lane, wr_addr, wr_data, k_len, start,
    output fd_out, rd_out, result_ld, busy, done
  );
endinterface

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - skewed A/B operand feeder for the NxN systolic array
// Optional macro SA_FEEDER_SIGNED_EN: sign-extend B operands onto the RD lanes.
module sa_skew_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int K_MAX      = 16
) (
  input logic             clk,
  input logic             rst,
  sa_skew_feeder_if.slave bus
);
  localparam int AW  = $clog2(K_MAX);
  localparam int TW  = $clog2(K_MAX + 2*N);
  localparam int DW2 = 2*DATA_WIDTH;
  localparam logic [TW-1:0] DRAIN_LAST = TW'(2*N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;
  logic [TW-1:0] t, t_n;
  logic [AW:0]   kl, kl_n;
  logic [TW-1:0] feed_last;
  logic [TW-1:0] d;

  logic [DATA_WIDTH-1:0] a_buf [N][K_MAX];
  logic [DATA_WIDTH-1:0] b_buf [N][K_MAX];

  logic [N*DATA_WIDTH-1:0] fd_n;
  logic [N*DW2-1:0]        rd_n;
  logic                    result_ld_n, busy_n, done_n;
  logic                    k_ok, start_ok, wr_ok;

  function automatic logic [DW2-1:0] ext(input logic [DATA_WIDTH-1:0] v);
`ifdef SA_FEEDER_SIGNED_EN
    return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
`else
    return {{DATA_WIDTH{1'b0}}, v};
`endif
  endfunction

  // The done cycle already sits in IDLE, so it is excluded explicitly to refuse a coincident restart.
  assign k_ok      = (bus.k_len != '0) && (bus.k_len <= (AW+1)'(K_MAX));
  assign start_ok  = bus.start && k_ok && (state == S_IDLE) && !bus.done;
  assign wr_ok     = bus.wr_en && (state == S_IDLE) && !start_ok;
  assign feed_last = TW'(kl) + TW'(2*N - 3);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (bus.wr_sel) b_buf[bus.wr_lane][bus.wr_addr] <= bus.wr_data;
      else            a_buf[bus.wr_lane][bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_n     = state;
    t_n         = t;
    kl_n        = kl;
    d           = '0;
    fd_n        = '0;
    rd_n        = '0;
    result_ld_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_n = S_FEED;
          t_n     = '0;
          kl_n    = bus.k_len;
        end
      end
      S_FEED: begin
        busy_n = 1'b1;
        for (int i = 0; i < N; i++) begin
          // t < lane wraps d far above K_MAX, so one compare covers both ends of the window.
          d = t - TW'(i);
          if (d < TW'(kl)) begin
            fd_n[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][AW'(d)];
            rd_n[i*DW2 +: DW2]               = ext(b_buf[i][AW'(d)]);
          end
        end
        if (t == feed_last) begin
          state_n = S_LOAD;
          t_n     = '0;
        end else begin
          t_n = t + TW'(1);
        end
      end
      S_LOAD: begin
        busy_n      = 1'b1;
        result_ld_n = 1'b1;
        state_n     = S_DRAIN;
        t_n         = '0;
      end
      S_DRAIN: begin
        busy_n = 1'b1;
        if (t == DRAIN_LAST) begin
          state_n = S_DONE;
          t_n     = '0;
        end else begin
          t_n = t + TW'(1);
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
        t_n     = '0;
      end
      default: begin
        state_n = S_IDLE;
        t_n     = '0;
      end
    endcase
  end

  // Outputs trail the state by one register stage, which gives the E1 first-data latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      t             <= '0;
      kl            <= '0;
      bus.fd_out    <= '0;
      bus.rd_out    <= '0;
      bus.result_ld <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      t             <= t_n;
      kl            <= kl_n;
      bus.fd_out    <= fd_n;
      bus.rd_out    <= rd_n;
      bus.result_ld <= result_ld_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
    end
  end
endmodule
